// File: rtl/mic1_io_pkg.sv
// Shared definitions for the Mic-1 memory-mapped UART: default register
// addresses, status bit positions and the common UART FSM state type.
package mic1_io_pkg;

    localparam logic [31:0] DEF_DATA_ADDR   = 32'hFFFF_FFFD;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'hFFFF_FFFC;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_RX_OVF   = 3;
    localparam int ST_RX_FERR  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous byte FIFO used for both UART directions. A push while full is
// accepted only when a pop happens in the same cycle.
module io_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_r[rd_ptr_r];

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mic1_uart_io.sv
// Memory-mapped 8N1 UART for the Mic-1 data bus with RX/TX FIFOs.
// Define MIC1_UART_LOOPBACK_EN to feed the receiver from the internal ser_tx.
module mic1_uart_io
    import mic1_io_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] DATA_ADDR    = DEF_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] io_rdata,
    output logic        io_hit,
    input  logic        ser_rx,
    output logic        ser_tx
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    logic data_sel_s, stat_sel_s, stat_clr_s;
    logic rd_data_r, rd_stat_r, wr_data_r;
    logic tx_ovf_r, rx_ovf_r, rx_ferr_r, rx_ferr_set_s;
    logic [4:0] status_s;
    logic rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic [7:0] rx_dout_s, tx_dout_s;
    logic rx_in_s, rx_meta_r, rx_sync_r, wdata_unused_s;

    uart_state_t   rx_state_r, rx_state_s, tx_state_r, tx_state_s;
    logic [CW-1:0] rx_cnt_r, rx_cnt_s, tx_cnt_r, tx_cnt_s;
    logic [2:0]    rx_bit_r, rx_bit_s, tx_bit_r, tx_bit_s;
    logic [7:0]    rx_shift_r, rx_shift_s, tx_shift_r, tx_shift_s;
    logic          rx_wait_r, rx_wait_s, ser_tx_r, ser_tx_s;

    assign data_sel_s     = (mem_addr == DATA_ADDR);
    assign stat_sel_s     = (mem_addr == STATUS_ADDR);
    assign io_hit         = data_sel_s | stat_sel_s;
    assign tx_push_s      = mem_write & data_sel_s & ~wr_data_r;
    assign rx_pop_s       = rd_data_r & ~mem_read;
    assign stat_clr_s     = rd_stat_r & ~mem_read;
    assign ser_tx         = ser_tx_r;
    assign wdata_unused_s = ^mem_wdata[31:8];

`ifdef MIC1_UART_LOOPBACK_EN
    logic rx_pin_unused_s;
    assign rx_pin_unused_s = ser_rx;
    assign rx_in_s         = ser_tx_r;
`else
    assign rx_in_s = ser_rx;
`endif

    io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push_s), .pop(rx_pop_s),
        .din(rx_shift_s), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s)
    );

    io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push_s), .pop(tx_pop_s),
        .din(mem_wdata[7:0]), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s)
    );

    // Read mux: status word or RX head, zero when nothing is addressed
    always_comb begin
        status_s              = 5'b0;
        status_s[ST_RX_AVAIL] = ~rx_empty_s;
        status_s[ST_TX_FULL]  = tx_full_s;
        status_s[ST_TX_OVF]   = tx_ovf_r;
        status_s[ST_RX_OVF]   = rx_ovf_r;
        status_s[ST_RX_FERR]  = rx_ferr_r;
        io_rdata              = 32'h0;
        if (data_sel_s && !rx_empty_s) begin
            io_rdata = {24'h0, rx_dout_s};
        end else if (stat_sel_s) begin
            io_rdata = {27'h0, status_s};
        end else begin
            io_rdata = 32'h0;
        end
    end

    // Strobe edge detectors, sticky flags (a set beats a same-cycle clear) and RX synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_r <= 1'b0;
            rd_stat_r <= 1'b0;
            wr_data_r <= 1'b0;
            tx_ovf_r  <= 1'b0;
            rx_ovf_r  <= 1'b0;
            rx_ferr_r <= 1'b0;
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rd_data_r <= mem_read & data_sel_s;
            rd_stat_r <= mem_read & stat_sel_s;
            wr_data_r <= mem_write & data_sel_s;
            tx_ovf_r  <= (tx_ovf_r & ~stat_clr_s) | (tx_push_s & tx_full_s & ~tx_pop_s);
            rx_ovf_r  <= (rx_ovf_r & ~stat_clr_s) | (rx_push_s & rx_full_s & ~rx_pop_s);
            rx_ferr_r <= (rx_ferr_r & ~stat_clr_s) | rx_ferr_set_s;
            rx_meta_r <= rx_in_s;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX next state: half-bit start check, then centre sampling of data and stop
    always_comb begin
        rx_state_s    = rx_state_r;
        rx_cnt_s      = rx_cnt_r + 1'b1;
        rx_bit_s      = rx_bit_r;
        rx_shift_s    = rx_shift_r;
        rx_wait_s     = rx_wait_r;
        rx_push_s     = 1'b0;
        rx_ferr_set_s = 1'b0;
        case (rx_state_r)
            IDLE: begin
                rx_cnt_s = {CW{1'b0}};
                if (!rx_sync_r) rx_state_s = START;
                else            rx_state_s = IDLE;
            end
            START: begin
                if (rx_cnt_r == HALF_END) begin
                    rx_cnt_s   = {CW{1'b0}};
                    rx_bit_s   = 3'd0;
                    rx_state_s = rx_sync_r ? IDLE : DATA;
                end else begin
                    rx_state_s = START;
                end
            end
            DATA: begin
                if (rx_cnt_r == BIT_END) begin
                    rx_cnt_s   = {CW{1'b0}};
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_bit_s   = rx_bit_r + 3'd1;
                    rx_state_s = (rx_bit_r == 3'd7) ? STOP : DATA;
                end else begin
                    rx_state_s = DATA;
                end
            end
            STOP: begin
                if (rx_wait_r) begin
                    rx_cnt_s = {CW{1'b0}};
                    if (rx_sync_r) begin
                        rx_wait_s  = 1'b0;
                        rx_state_s = IDLE;
                    end else begin
                        rx_state_s = STOP;
                    end
                end else if (rx_cnt_r == BIT_END) begin
                    rx_cnt_s = {CW{1'b0}};
                    if (rx_sync_r) begin
                        rx_push_s  = 1'b1;
                        rx_state_s = IDLE;
                    end else begin
                        rx_ferr_set_s = 1'b1;
                        rx_wait_s     = 1'b1;
                    end
                end else begin
                    rx_state_s = STOP;
                end
            end
            default: begin
                rx_state_s = IDLE;
                rx_cnt_s   = {CW{1'b0}};
                rx_wait_s  = 1'b0;
            end
        endcase
    end

    // TX next state: start, 8 data bits LSB first, stop; chain straight into the next frame
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r + 1'b1;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        ser_tx_s   = ser_tx_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            IDLE: begin
                tx_cnt_s = {CW{1'b0}};
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_s = tx_dout_s;
                    tx_state_s = START;
                    ser_tx_s   = 1'b0;
                end else begin
                    ser_tx_s = 1'b1;
                end
            end
            START: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s   = {CW{1'b0}};
                    tx_bit_s   = 3'd0;
                    ser_tx_s   = tx_shift_r[0];
                    tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    tx_state_s = DATA;
                end else begin
                    tx_state_s = START;
                end
            end
            DATA: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s = {CW{1'b0}};
                    tx_bit_s = tx_bit_r + 3'd1;
                    if (tx_bit_r == 3'd7) begin
                        ser_tx_s   = 1'b1;
                        tx_state_s = STOP;
                    end else begin
                        ser_tx_s   = tx_shift_r[0];
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    end
                end else begin
                    tx_state_s = DATA;
                end
            end
            STOP: begin
                if (tx_cnt_r == BIT_END) begin
                    tx_cnt_s = {CW{1'b0}};
                    if (!tx_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_s = tx_dout_s;
                        tx_state_s = START;
                        ser_tx_s   = 1'b0;
                    end else begin
                        tx_state_s = IDLE;
                        ser_tx_s   = 1'b1;
                    end
                end else begin
                    tx_state_s = STOP;
                end
            end
            default: begin
                tx_state_s = IDLE;
                tx_cnt_s   = {CW{1'b0}};
                ser_tx_s   = 1'b1;
            end
        endcase
    end

    // RX and TX state registers; reset truncates any frame and idles the line high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= IDLE;
            rx_cnt_r   <= {CW{1'b0}};
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_wait_r  <= 1'b0;
            tx_state_r <= IDLE;
            tx_cnt_r   <= {CW{1'b0}};
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            ser_tx_r   <= 1'b1;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_wait_r  <= rx_wait_s;
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            ser_tx_r   <= ser_tx_s;
        end
    end

endmodule

// File: tb/tb_mic1_uart_io.sv
// Directed bench for mic1_uart_io with CLKS_PER_BIT=8 and FIFO_DEPTH=16.
module tb_mic1_uart_io;
    localparam int          CPB   = 8;
    localparam logic [31:0] DADDR = 32'hFFFF_FFFD;
    localparam logic [31:0] SADDR = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] io_rdata;
    logic        io_hit;
    logic        ser_rx;
    logic        ser_tx;

    int tests = 0;
    int fails = 0;

    mic1_uart_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .io_rdata(io_rdata),
        .io_hit(io_hit), .ser_rx(ser_rx), .ser_tx(ser_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_data(input logic [7:0] b);
        mem_addr  = DADDR;
        mem_wdata = {24'h0, b};
        mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_pulse(input logic [31:0] a);
        mem_addr = a;
        mem_read = 1'b1;
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ser_rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        ser_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_addr = a;
        #1;
        check(tag, io_rdata, exp);
    endtask

    initial begin
        logic [9:0] fr;
        reset = 1'b1; mem_addr = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        mem_wdata = 32'h0; ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state and address decode
        check("rst_ser_tx", {31'h0, ser_tx}, 32'h1);
        peek("rst_status", SADDR, 32'h0);
        check("hit_status", {31'h0, io_hit}, 32'h1);
        peek("rst_data", DADDR, 32'h0);
        check("hit_data", {31'h0, io_hit}, 32'h1);
        peek("miss_rdata", 32'h0000_0010, 32'h0);
        check("miss_hit", {31'h0, io_hit}, 32'h0);

        // TX frame 0x41: start bit two cycles after the write edge
        mem_addr = DADDR; mem_wdata = 32'h0000_0041; mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        check("tx_idle_after_push", {31'h0, ser_tx}, 32'h1);
        @(negedge clk);
        check("tx_start_edge", {31'h0, ser_tx}, 32'h0);
        repeat (CPB/2) @(negedge clk);
        fr = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check("tx_bit", {31'h0, ser_tx}, {31'h0, fr[k]});
            repeat (CPB) @(negedge clk);
        end

        // RX frame 0x33, strobe held 3 cycles pops exactly once
        send_frame(8'h33, 1'b1);
        peek("rx33_status", SADDR, 32'h1);
        mem_addr = DADDR; mem_read = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("rx33_hold", io_rdata, 32'h33);
            @(negedge clk);
        end
        mem_read = 1'b0;
        @(negedge clk);
        peek("rx33_after_pop", DADDR, 32'h0);
        rd_pulse(DADDR);
        peek("rx33_empty_status", SADDR, 32'h0);

        // TX overflow: one byte in flight, then 17 pushes into 16 slots
        wr_data(8'h00);
        @(negedge clk);
        for (int n = 0; n < 17; n++) wr_data(8'(n + 1));
        peek("tx_full_ovf", SADDR, 32'h6);
        rd_pulse(SADDR);
        peek("tx_ovf_cleared", SADDR, 32'h2);
        check("tx_busy_low", {31'h0, ser_tx}, 32'h0);

        // Reset mid-frame: line high asynchronously, everything cleared
        #1 reset = 1'b1;
        #1 check("rst_async_tx", {31'h0, ser_tx}, 32'h1);
        peek("rst_mid_status", SADDR, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_tx_stays_idle", {31'h0, ser_tx}, 32'h1);
        peek("rst_fifo_empty", SADDR, 32'h0);

        // Framing error then a good frame
        send_frame(8'h55, 1'b0);
        peek("ferr_status", SADDR, 32'h10);
        peek("ferr_no_data", DADDR, 32'h0);
        send_frame(8'h0A, 1'b1);
        peek("after_ferr_status", SADDR, 32'h11);
        peek("after_ferr_data", DADDR, 32'h0A);
        rd_pulse(DADDR);
        rd_pulse(SADDR);
        peek("ferr_cleared", SADDR, 32'h0);

        // Two-cycle glitch is rejected
        ser_rx = 1'b0;
        repeat (2) @(negedge clk);
        ser_rx = 1'b1;
        repeat (16) @(negedge clk);
        peek("glitch_status", SADDR, 32'h0);
        peek("glitch_data", DADDR, 32'h0);

        // Two queued bytes come out in order, one per access
        send_frame(8'hC3, 1'b1);
        send_frame(8'h5A, 1'b1);
        mem_addr = DADDR; mem_read = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("fifo_hold_c3", io_rdata, 32'hC3);
            @(negedge clk);
        end
        mem_read = 1'b0;
        @(negedge clk);
        peek("fifo_second", DADDR, 32'h5A);
        peek("fifo_second_status", SADDR, 32'h1);
        rd_pulse(DADDR);
        peek("fifo_drained", SADDR, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
